// File: rtl/census_cost_pkg.sv
// Shared types and width helpers for the census Hamming-cost accumulator.
package census_cost_pkg;

    // A 4-bit nibble holds 0..4 set bits, so each per-nibble count fits in 3 bits.
    localparam int NIB_CNT_W  = 3;
    localparam int COST_W_DEF = 12;

    typedef logic [NIB_CNT_W-1:0]  nib_cnt_t;
    typedef logic [COST_W_DEF-1:0] cost_t;

    // Bits needed to hold a popcount of 0..census_w.
    function automatic int pc_width(input int census_w);
        return $clog2(census_w + 1);
    endfunction

endpackage

// File: rtl/popcnt_tree.sv
// Combinational adder tree: sums NIBS per-nibble counts into one PC_W-bit word count.
module popcnt_tree
    import census_cost_pkg::*;
#(
    parameter int NIBS = 8,
    parameter int PC_W = 6
) (
    input  nib_cnt_t [NIBS-1:0] nib_cnt,
    output logic     [PC_W-1:0] sum
);

    logic [PC_W-1:0] lvl [NIBS];

    // Pairwise reduction: each pass folds entries 'step' apart, halving the live count.
    always_comb begin
        for (int i = 0; i < NIBS; i++) begin
            lvl[i] = PC_W'(nib_cnt[i]);
        end
        for (int step = 1; step < NIBS; step = step * 2) begin
            for (int i = 0; i + step < NIBS; i = i + 2 * step) begin
                lvl[i] = lvl[i] + lvl[i + step];
            end
        end
        sum = lvl[0];
    end

endmodule

// File: rtl/census_cost_accum.sv
// Census block matching cost: XOR + popcount per word pair, accumulated per block.
// Pipeline: S1 nibble counts -> S2 word count -> S3 accumulator / output register.
// Optional: define CENSUS_COST_SATURATE_EN for a saturating accumulator and an
// out_sat flag; otherwise the block cost wraps modulo 2^COST_W.
module census_cost_accum
    import census_cost_pkg::*;
#(
    parameter int CENSUS_W = 32,
    parameter int COST_W   = 12,
    parameter int TAG_W    = 7
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CENSUS_W-1:0] in_left,
    input  logic [CENSUS_W-1:0] in_right,
    input  logic                in_last,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [COST_W-1:0]   out_cost,
    output logic [TAG_W-1:0]    out_tag,
    output logic                busy
`ifdef CENSUS_COST_SATURATE_EN
    ,
    output logic                out_sat
`endif
);

    localparam int NIBS = CENSUS_W / 4;
    localparam int PC_W = pc_width(CENSUS_W);

    // A held, unaccepted result freezes the whole pipeline.
    logic stall;
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // ---------------- S1: per-nibble popcount of the XOR ----------------
    logic [CENSUS_W-1:0]  diff;
    nib_cnt_t [NIBS-1:0]  nib_cnt_d;

    logic                 s1_valid;
    logic                 s1_last;
    logic [TAG_W-1:0]     s1_tag;
    nib_cnt_t [NIBS-1:0]  s1_cnt;

    // Nibble lookup: count set bits of each 4-bit slice of the mismatch word.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        nib_cnt_d = '0;
        diff      = in_left ^ in_right;
        for (int i = 0; i < NIBS; i++) begin
            nib_cnt_d[i] = nib_cnt_t'(diff[4*i])   + nib_cnt_t'(diff[4*i+1])
                         + nib_cnt_t'(diff[4*i+2]) + nib_cnt_t'(diff[4*i+3]);
        end
    end

    // S1 register: capture nibble counts, last flag and tag of an accepted pair.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_tag   <= '0;
            s1_cnt   <= '0;
        end else if (!stall) begin
            // NOTE: non-blocking so every stage reads the pre-edge value of the one before it.
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_last <= in_last;
                s1_tag  <= in_tag;
                s1_cnt  <= nib_cnt_d;
            end
        end
    end

    // ---------------- S2: word popcount ----------------
    logic [PC_W-1:0]  word_cnt;
    logic             s2_valid;
    logic             s2_last;
    logic [TAG_W-1:0] s2_tag;
    logic [PC_W-1:0]  s2_cnt;

    popcnt_tree #(
        .NIBS (NIBS),
        .PC_W (PC_W)
    ) u_popcnt_tree (
        .nib_cnt (s1_cnt),
        .sum     (word_cnt)
    );

    // S2 register: hold the summed word count alongside its last/tag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_tag   <= '0;
            s2_cnt   <= '0;
        end else if (!stall) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_last <= s1_last;
                s2_tag  <= s1_tag;
                s2_cnt  <= word_cnt;
            end
        end
    end

    // ---------------- S3: block accumulator ----------------
    logic [COST_W-1:0] acc;
    logic [COST_W-1:0] acc_sum;
    logic              acc_partial;

`ifdef CENSUS_COST_SATURATE_EN
    logic [COST_W:0]   acc_wide;
    logic              acc_sat;
    logic              sum_sat;

    // Saturating add: once the block has hit max it stays there until the boundary.
    always_comb begin
        acc_wide = {1'b0, acc} + (COST_W+1)'(s2_cnt);
        sum_sat  = acc_sat || acc_wide[COST_W];
        acc_sum  = sum_sat ? {COST_W{1'b1}} : acc_wide[COST_W-1:0];
    end
`else
    // Wrapping add of the zero-extended word count.
    always_comb begin
        acc_sum = acc + COST_W'(s2_cnt);
    end
`endif

    // Accumulate words; on the last word publish the total and restart from zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc         <= '0;
            acc_partial <= 1'b0;
            out_valid   <= 1'b0;
            out_cost    <= '0;
            out_tag     <= '0;
`ifdef CENSUS_COST_SATURATE_EN
            acc_sat     <= 1'b0;
            out_sat     <= 1'b0;
`endif
        end else if (!stall) begin
            // Not stalled means any held result is being accepted this cycle.
            out_valid <= 1'b0;
            if (s2_valid) begin
                if (s2_last) begin
                    out_valid   <= 1'b1;
                    out_cost    <= acc_sum;
                    out_tag     <= s2_tag;
                    acc         <= '0;
                    acc_partial <= 1'b0;
`ifdef CENSUS_COST_SATURATE_EN
                    out_sat     <= sum_sat;
                    acc_sat     <= 1'b0;
`endif
                end else begin
                    acc         <= acc_sum;
                    acc_partial <= 1'b1;
`ifdef CENSUS_COST_SATURATE_EN
                    acc_sat     <= sum_sat;
`endif
                end
            end
        end
    end

    assign busy = s1_valid || s2_valid || acc_partial;

endmodule

// File: tb/tb_census_cost_accum.sv
// Directed bench for census_cost_accum: single-word vector table plus hand-written
// multi-word, back-to-back, stall, overflow and mid-block reset sequences.
// A second instance with COST_W=6 covers the overflow behaviour.
module tb_census_cost_accum;

    localparam int CENSUS_W     = 32;
    localparam int COST_W       = 12;
    localparam int TAG_W        = 7;
    localparam int SMALL_COST_W = 6;
`ifdef CENSUS_COST_SATURATE_EN
    localparam int SMALL_EXP    = 63;
    localparam int SMALL_SAT    = 1;
`else
    localparam int SMALL_EXP    = 32;
    localparam int SMALL_SAT    = 0;
`endif

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic                    in_valid, in_last, out_ready;
    logic [CENSUS_W-1:0]     in_left, in_right;
    logic [TAG_W-1:0]        in_tag;
    logic                    in_ready, out_valid, busy;
    logic [COST_W-1:0]       out_cost;
    logic [TAG_W-1:0]        out_tag;
    logic                    s_in_ready, s_out_valid, s_busy;
    logic [SMALL_COST_W-1:0] s_out_cost;
    logic [TAG_W-1:0]        s_out_tag;
`ifdef CENSUS_COST_SATURATE_EN
    logic                    out_sat, s_out_sat;
`endif

    census_cost_accum #(.CENSUS_W(CENSUS_W), .COST_W(COST_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_left(in_left), .in_right(in_right), .in_last(in_last), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_cost(out_cost),
        .out_tag(out_tag), .busy(busy)
`ifdef CENSUS_COST_SATURATE_EN
        , .out_sat(out_sat)
`endif
    );

    census_cost_accum #(.CENSUS_W(CENSUS_W), .COST_W(SMALL_COST_W), .TAG_W(TAG_W)) dut_small (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_left(in_left), .in_right(in_right), .in_last(in_last), .in_tag(in_tag),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_cost(s_out_cost),
        .out_tag(s_out_tag), .busy(s_busy)
`ifdef CENSUS_COST_SATURATE_EN
        , .out_sat(s_out_sat)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cost;
        int tag;
        int sat;
        int cyc;
    } res_t;

    res_t res_q[$];
    res_t small_q[$];

    int tests  = 0;
    int failed = 0;

    // Inputs change at posedge+1, so the negedge sees a settled handshake.
    always @(negedge clk) begin
        res_t r;
        if (reset_n && out_valid && out_ready) begin
            r.cost = int'(out_cost);
            r.tag  = int'(out_tag);
`ifdef CENSUS_COST_SATURATE_EN
            r.sat  = int'(out_sat);
`else
            r.sat  = 0;
`endif
            r.cyc  = cyc;
            res_q.push_back(r);
        end
        if (reset_n && s_out_valid && out_ready) begin
            r.cost = int'(s_out_cost);
            r.tag  = int'(s_out_tag);
`ifdef CENSUS_COST_SATURATE_EN
            r.sat  = int'(s_out_sat);
`else
            r.sat  = 0;
`endif
            r.cyc  = cyc;
            small_q.push_back(r);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one pair and hold it until accepted; returns at posedge+1.
    task automatic send(input logic [31:0] l, input logic [31:0] r,
                        input logic last, input logic [TAG_W-1:0] tag);
        int n;
        n = 0;
        in_left  = l;
        in_right = r;
        in_last  = last;
        in_tag   = tag;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait (bounded) for the next main-instance result and compare it.
    task automatic expect_result(input string name, input int exp_cost, input int exp_tag,
                                 input int exp_sat, output int got_cyc);
        int n;
        res_t r;
        n = 0;
        got_cyc = -1;
        while (res_q.size() == 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, "_present"}, 32'(res_q.size() != 0), 32'd1);
        if (res_q.size() != 0) begin
            r = res_q.pop_front();
            got_cyc = r.cyc;
            check({name, "_cost"}, r.cost, exp_cost);
            check({name, "_tag"}, r.tag, exp_tag);
`ifdef CENSUS_COST_SATURATE_EN
            check({name, "_sat"}, r.sat, exp_sat);
`else
            if (exp_sat != 0) check({name, "_sat"}, r.sat, exp_sat);
`endif
        end
    endtask

    typedef struct {
        logic [31:0]      left;
        logic [31:0]      right;
        logic [TAG_W-1:0] tag;
        int               exp_cost;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c1, c2, stable_cost, stable_tag;
        res_t r;

        // One-word blocks: cost is the popcount of left ^ right.
        vecs[0] = '{32'h0000_0000, 32'h0000_0000, 7'd1,   0};
        vecs[1] = '{32'hAAAA_AAAA, 32'h5555_5555, 7'd127, 32};
        vecs[2] = '{32'hF0F0_F0F0, 32'hF0F0_F0F0, 7'd2,   0};
        vecs[3] = '{32'h1234_5678, 32'h0000_0000, 7'd3,   13};
        vecs[4] = '{32'h0000_0001, 32'h8000_0000, 7'd4,   2};
        vecs[5] = '{32'h0000_00FF, 32'h0000_0000, 7'd6,   8};
        vecs[6] = '{32'hDEAD_BEEF, 32'hDEAD_BEEE, 7'd100, 1};
        vecs[7] = '{32'h0000_0000, 32'hFFFF_0000, 7'd64,  16};

        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_left   = '0;
        in_right  = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        reset_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_cost", 32'(out_cost), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_small_in_ready", 32'(s_in_ready), 32'd1);
`ifdef CENSUS_COST_SATURATE_EN
        check("rst_out_sat", 32'(out_sat), 32'd0);
`endif
        @(posedge clk);
        #1;

        // Latency: last word accepted in cycle t -> out_valid in cycle t+3
        send(32'hFFFF_FFFF, 32'h0, 1'b1, 7'd5);
        @(negedge clk);
        check("lat_t1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_t2_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_t3_valid", 32'(out_valid), 32'd1);
        check("lat_t3_cost", 32'(out_cost), 32'd32);
        check("lat_t3_tag", 32'(out_tag), 32'd5);
        expect_result("lat", 32, 5, 0, c1);
        @(posedge clk);
        #1;

        // Table of single-word blocks
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].left, vecs[i].right, 1'b1, vecs[i].tag);
            expect_result($sformatf("vec%0d", i), vecs[i].exp_cost, int'(vecs[i].tag), 0, c1);
            @(posedge clk);
            #1;
        end

        // 4-word block, popcounts 1,2,3,4 -> 10; tag on non-last words ignored
        send(32'h1, 32'h0, 1'b0, 7'd55);
        @(negedge clk);
        check("blk4_w1_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        send(32'h3, 32'h0, 1'b0, 7'd66);
        @(negedge clk);
        check("blk4_w2_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        send(32'h7, 32'h0, 1'b0, 7'd77);
        @(negedge clk);
        check("blk4_w3_busy", 32'(busy), 32'd1);
        check("blk4_no_early_out", 32'(res_q.size()), 32'd0);
        @(posedge clk);
        #1;
        send(32'hF, 32'h0, 1'b1, 7'd9);
        @(negedge clk);
        check("blk4_last_busy", 32'(busy), 32'd1);
        expect_result("blk4", 10, 9, 0, c1);
        repeat (3) @(negedge clk);
        check("blk4_single_out", 32'(res_q.size()), 32'd0);
        check("blk4_idle_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // Idle bubbles inside a block: 5 + 3 = 8, accumulator holds between words
        send(32'h1F, 32'h0, 1'b0, 7'd11);
        repeat (2) begin
            @(negedge clk);
            check("bubble_busy", 32'(busy), 32'd1);
            @(posedge clk);
            #1;
        end
        send(32'h7, 32'h0, 1'b1, 7'd3);
        expect_result("bubble", 8, 3, 0, c1);
        @(posedge clk);
        #1;

        // Back-to-back 2-word blocks, no gap: 6+7=13/tag1, 0+32=32/tag2
        send(32'h3F, 32'h0, 1'b0, 7'd0);
        send(32'h7F, 32'h0, 1'b0 | 1'b1, 7'd1);
        send(32'h0, 32'h0, 1'b0, 7'd0);
        send(32'hFFFF_FFFF, 32'h0, 1'b1, 7'd2);
        expect_result("b2b_first", 13, 1, 0, c1);
        expect_result("b2b_second", 32, 2, 0, c2);
        // Results follow the two-cycle spacing of the last words with no extra gap.
        check("b2b_spacing", c2 - c1, 32'd2);
        @(posedge clk);
        #1;

        // Stall: result held 5 cycles while the next block streams in
        out_ready = 1'b0;
        send(32'hF, 32'h0, 1'b1, 7'd10);
        fork
            begin
                send(32'hFF, 32'h0, 1'b0, 7'd0);
                send(32'hFF, 32'h0, 1'b0, 7'd0);
                send(32'h1, 32'h0, 1'b1, 7'd11);
            end
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (!out_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                check("stall_out_valid", 32'(out_valid), 32'd1);
                stable_cost = 4;
                stable_tag  = 10;
                for (int i = 0; i < 5; i++) begin
                    check("stall_in_ready", 32'(in_ready), 32'd0);
                    check("stall_valid_held", 32'(out_valid), 32'd1);
                    check("stall_cost_held", 32'(out_cost), stable_cost);
                    check("stall_tag_held", 32'(out_tag), stable_tag);
                    @(negedge clk);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        expect_result("stall_a", 4, 10, 0, c1);
        expect_result("stall_b", 17, 11, 0, c1);
        @(posedge clk);
        #1;

        // Overflow on the COST_W=6 instance: 3 x 32 = 96
        small_q.delete();
        send(32'hFFFF_FFFF, 32'h0, 1'b0, 7'd0);
        send(32'hFFFF_FFFF, 32'h0, 1'b0, 7'd0);
        @(negedge clk);
        check("ovf_small_busy", 32'(s_busy), 32'd1);
        @(posedge clk);
        #1;
        send(32'hFFFF_FFFF, 32'h0, 1'b1, 7'd20);
        expect_result("ovf_main", 96, 20, 0, c1);
        check("ovf_small_present", 32'(small_q.size()), 32'd1);
        if (small_q.size() != 0) begin
            r = small_q.pop_front();
            check("ovf_small_cost", r.cost, SMALL_EXP);
            check("ovf_small_tag", r.tag, 32'd20);
            check("ovf_small_sat", r.sat, SMALL_SAT);
        end
        @(posedge clk);
        #1;

        // Reset mid-block with a pending, unaccepted result
        out_ready = 1'b0;
        send(32'h1, 32'h0, 1'b1, 7'd3);
        send(32'hF, 32'h0, 1'b0, 7'd0);
        send(32'hFF, 32'h0, 1'b0, 7'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("prerst_out_valid", 32'(out_valid), 32'd1);
        check("prerst_busy", 32'(busy), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_cost", 32'(out_cost), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_nothing_emitted", 32'(res_q.size()), 32'd0);
        send(32'h7F, 32'h0, 1'b1, 7'd4);
        expect_result("postrst", 7, 4, 0, c1);

        repeat (5) @(negedge clk);
        check("no_extra_results", 32'(res_q.size()), 32'd0);
        check("final_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
